// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: mode-0 SPI slave with oversampled pins, byte RX/TX and completion pulses
module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_tx_done,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_done,
  output logic                  o_busy,
  output logic                  o_abort,
  input  logic                  i_spi_cs,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_mosi,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_en
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [2:0] cs_sr, sck_sr;
  logic [1:0] mosi_sr;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CW-1:0] bit_cnt;
  logic reload;
  logic cs_fall, cs_rise, sck_rise, sck_fall, mosi;
  assign cs_fall  = cs_sr[2] & ~cs_sr[1];
  assign cs_rise  = ~cs_sr[2] & cs_sr[1];
  assign sck_rise = ~sck_sr[2] & sck_sr[1];
  assign sck_fall = sck_sr[2] & ~sck_sr[1];
  assign mosi     = mosi_sr[1];
  // Two-stage synchronisers plus a previous-value flop on CS/SCLK; CS resets low so a CS held low at release is not seen as a fall
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cs_sr   <= '0;
      sck_sr  <= '0;
      mosi_sr <= '0;
    end else begin
      cs_sr   <= {cs_sr[1:0], i_spi_cs};
      sck_sr  <= {sck_sr[1:0], i_spi_clk};
      mosi_sr <= {mosi_sr[0], i_spi_mosi};
    end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Next state: a frame opens on CS fall and closes on CS rise
  always_comb
    state_d = (state_q == IDLE && cs_fall) ? XFER :
              (state_q == XFER && cs_rise) ? IDLE : state_q;
  // Outputs derived from state; MISO is the top of the TX shifter while the frame is live
  always_comb begin
    o_busy        = state_q == XFER;
    o_spi_miso_en = o_busy;
    o_spi_miso    = o_busy & tx_shift[DATA_WIDTH-1];
  end
  // Shift datapath: CS rise wins over a coincident SCLK edge
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      reload    <= 1'b0;
      o_rx_data <= '0;
      o_rx_done <= 1'b0;
      o_tx_done <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      o_tx_done <= 1'b0;
      o_abort   <= 1'b0;
      if (state_q == IDLE) begin
        if (cs_fall) begin
          tx_shift <= i_tx_data;
          bit_cnt  <= '0;
          reload   <= 1'b0;
        end
      end else if (cs_rise) begin
        o_abort <= bit_cnt != '0;
        bit_cnt <= '0;
        reload  <= 1'b0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi};
        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
          o_rx_data <= {rx_shift, mosi};
          o_rx_done <= 1'b1;
          o_tx_done <= 1'b1;
          bit_cnt   <= '0;
          reload    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (sck_fall) begin
        tx_shift <= reload ? i_tx_data : {tx_shift[DATA_WIDTH-2:0], 1'b0};
        reload   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed vector table plus hand sequences for bursts, abort, noise, reset and max rate
module tb_spi_slave_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_done, rx_done, busy, abort, miso, miso_en;
  logic [7:0] rx_data;
  logic spi_cs = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  int nvec = 0, nfail = 0;
  int rx_cnt = 0, tx_cnt = 0, abort_cnt = 0, busy_cnt = 0, skew_cnt = 0, wide_cnt = 0;
  logic [7:0] rx_log [0:1023];
  logic prev_rx = 1'b0, prev_tx = 1'b0, prev_ab = 1'b0;

  spi_slave_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .o_tx_done(tx_done),
    .o_rx_data(rx_data), .o_rx_done(rx_done), .o_busy(busy), .o_abort(abort),
    .i_spi_cs(spi_cs), .i_spi_clk(spi_clk), .i_spi_mosi(spi_mosi),
    .o_spi_miso(miso), .o_spi_miso_en(miso_en)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling clock edge
  always @(negedge clk) begin
    if (rx_done) begin
      rx_log[rx_cnt & 1023] = rx_data;
      rx_cnt++;
    end
    if (tx_done) tx_cnt++;
    if (abort) abort_cnt++;
    if (busy || miso_en) busy_cnt++;
    if (rx_done !== tx_done) skew_cnt++;
    if ((rx_done && prev_rx) || (tx_done && prev_tx) || (abort && prev_ab)) wide_cnt++;
    prev_rx = rx_done;
    prev_tx = tx_done;
    prev_ab = abort;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: drive nbits MSB first, sample MISO just before each rise; at a byte end
  // wait (bounded by the high phase) for o_tx_done and optionally present the next TX byte
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                          input bit upd, input logic [7:0] nxt, output logic [7:0] mi);
    bit seen;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      wait_clk(half);
      mi[7-i] = miso;
      spi_clk = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < half; k++) begin
        @(negedge clk);
        if (tx_done && !seen) begin
          seen = 1'b1;
          if (upd) tx_data = nxt;
        end
      end
      if (i == 7) chk("tx_done_in_high_phase", 32'(seen), 32'd1);
      spi_clk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [7:0] tx, input logic [7:0] mo, input int half,
                          output logic [7:0] mi);
    tx_data = tx;
    spi_cs = 1'b0;
    spi_bits(mo, 8, half, 1'b0, 8'h00, mi);
    wait_clk(half);
    spi_cs = 1'b1;
    wait_clk(half + 4);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_mi;
  } vec_t;

  initial begin
    vec_t vt [6];
    logic [7:0] mi, b0, b1, b2, prior;
    int base, tbase, abase, bbase;
    logic [7:0] rtx [256];
    logic [7:0] rmo [256];
    vt[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vt[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vt[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vt[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81};
    vt[4] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vt[5] = '{8'h01, 8'h80, 8'h80, 8'h01};

    wait_clk(3);
    chk("reset_outputs", {rx_data, rx_done, tx_done, busy, abort, miso, miso_en}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);
    chk("idle_after_reset", {busy, miso_en, miso}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      base = rx_cnt;
      tbase = tx_cnt;
      do_frame(vt[v].tx, vt[v].mo, 8, mi);
      chk("vec_rx_pulses", 32'(rx_cnt - base), 32'd1);
      chk("vec_tx_pulses", 32'(tx_cnt - tbase), 32'd1);
      chk("vec_rx_log", rx_log[base & 1023], vt[v].exp_rx);
      chk("vec_rx_data", rx_data, vt[v].exp_rx);
      chk("vec_miso", mi, vt[v].exp_mi);
      chk("vec_busy_after", {busy, miso_en}, 32'd0);
    end

    base = rx_cnt;
    tx_data = 8'h10;
    spi_cs = 1'b0;
    spi_bits(8'h01, 8, 8, 1'b1, 8'h20, b0);
    spi_bits(8'h02, 8, 8, 1'b1, 8'h30, b1);
    spi_bits(8'h03, 8, 8, 1'b1, 8'h00, b2);
    wait_clk(8);
    spi_cs = 1'b1;
    wait_clk(12);
    chk("burst_rx_pulses", 32'(rx_cnt - base), 32'd3);
    chk("burst_rx0", rx_log[base & 1023], 8'h01);
    chk("burst_rx1", rx_log[(base + 1) & 1023], 8'h02);
    chk("burst_rx2", rx_log[(base + 2) & 1023], 8'h03);
    chk("burst_mi0", b0, 8'h10);
    chk("burst_mi1", b1, 8'h20);
    chk("burst_mi2", b2, 8'h30);

    prior = rx_data;
    base = rx_cnt;
    abase = abort_cnt;
    tx_data = 8'h00;
    spi_cs = 1'b0;
    spi_bits(8'hB7, 5, 8, 1'b0, 8'h00, mi);
    wait_clk(8);
    spi_cs = 1'b1;
    wait_clk(12);
    chk("abort_pulses", 32'(abort_cnt - abase), 32'd1);
    chk("abort_no_rx_done", 32'(rx_cnt - base), 32'd0);
    chk("abort_rx_kept", rx_data, prior);
    abase = abort_cnt;
    do_frame(8'h3C, 8'hFF, 8, mi);
    chk("after_abort_rx", rx_data, 8'hFF);
    chk("after_abort_miso", mi, 8'h3C);
    chk("full_frame_no_abort", 32'(abort_cnt - abase), 32'd0);

    base = rx_cnt;
    tbase = tx_cnt;
    abase = abort_cnt;
    bbase = busy_cnt;
    for (int i = 0; i < 20; i++) begin
      spi_mosi = i[0];
      wait_clk(4);
      spi_clk = 1'b1;
      wait_clk(4);
      spi_clk = 1'b0;
    end
    wait_clk(6);
    chk("noise_pulses", 32'((rx_cnt - base) + (tx_cnt - tbase) + (abort_cnt - abase)), 32'd0);
    chk("noise_busy_cycles", 32'(busy_cnt - bbase), 32'd0);

    base = rx_cnt;
    tx_data = 8'hC3;
    spi_cs = 1'b0;
    spi_bits(8'h5A, 4, 8, 1'b0, 8'h00, mi);
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {rx_data, rx_done, tx_done, busy, abort, miso, miso_en}, 32'd0);
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    chk("cs_low_at_release_idle", {busy, miso_en}, 32'd0);
    spi_cs = 1'b1;
    wait_clk(8);
    do_frame(8'h96, 8'h5A, 8, mi);
    chk("post_reset_rx", rx_data, 8'h5A);
    chk("post_reset_rx_pulses", 32'(rx_cnt - base), 32'd1);
    chk("post_reset_miso", mi, 8'h96);

    for (int f = 0; f < 256; f++) begin
      rtx[f] = 8'($urandom);
      rmo[f] = 8'($urandom);
    end
    for (int f = 0; f < 256; f++) begin
      base = rx_cnt;
      do_frame(rtx[f], rmo[f], 4, mi);
      chk("maxrate_rx", (rx_cnt - base == 1) ? 32'(rx_log[base & 1023]) : 32'hFFFF_FFFF, 32'(rmo[f]));
      chk("maxrate_miso", mi, rtx[f]);
    end

    chk("rx_tx_done_same_cycle", 32'(skew_cnt), 32'd0);
    chk("single_cycle_pulses", 32'(wide_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Mode-0 SPI slave endpoint. It pairs with the team's SPI master and serves as the peripheral side of the SPI link on the FPGA. It oversamples the external CS/SCLK/MOSI pins with the local system clock and deserialises MOSI into bytes. In the same transfer it serialises a host-supplied byte onto MISO, and it flags byte completion to the local logic with single-cycle pulses.

## Interface
- DATA_WIDTH, 8, bits per SPI frame; MSB first.
- i_clk  in  1  system clock; must be ≥ 8× SCLK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tx_data  in  DATA_WIDTH  byte to send on MISO; sampled at each load event.
- o_tx_done  out  1  one-cycle pulse: current TX byte fully shifted out.
- o_rx_data  out  DATA_WIDTH  last completely received byte; holds until next completion.
- o_rx_done  out  1  one-cycle pulse: o_rx_data updated this cycle.
- o_busy  out  1  synchronised chip-select active (frame in progress).
- o_abort  out  1  one-cycle pulse: CS released with a partial frame.
- i_spi_cs  in  1  chip select, active low, asynchronous to i_clk.
- i_spi_clk  in  1  SCLK, CPOL=0, asynchronous to i_clk.
- i_spi_mosi  in  1  master-out data.
- o_spi_miso  out  1  slave-out data.
- o_spi_miso_en  out  1  MISO output enable; equals o_busy. The pad tristates when this is 0.

## Operation
- **Synchronisation**
  - i_spi_cs, i_spi_clk and i_spi_mosi each pass through a 2-flop synchroniser.
  - A third "previous" flop on CS and SCLK provides edge detection.
  - MOSI is taken from the synchronised stage aligned with SCLK.
- **States**
  - IDLE: CS high.
    - On CS falling: load tx_shift ← i_tx_data, bit_cnt ← 0, o_busy ← 1, o_spi_miso ← i_tx_data[MSB]; go to XFER.
  - XFER, SCLK rising:
    - rx_shift ← {rx_shift[DW-2:0], mosi}; bit_cnt++.
    - When bit_cnt == DW-1 (the last bit):
      - o_rx_data ← {rx_shift[DW-2:0], mosi}.
      - Pulse o_rx_done and o_tx_done.
      - bit_cnt wraps to 0.
      - Set reload flag.
  - XFER, SCLK falling:
    - If reload is set: tx_shift ← i_tx_data, o_spi_miso ← i_tx_data[MSB], clear reload.
    - Otherwise: tx_shift shifts left and o_spi_miso ← next bit.
    - The first falling edge after CS low with no completed byte is a normal shift.
  - XFER, CS rising: go to IDLE.
    - If bit_cnt != 0, pulse o_abort; o_rx_data is unchanged and o_rx_done does not pulse.
    - o_busy ← 0, o_spi_miso ← 0, reload cleared.
- **Bursts**: back-to-back bytes within one CS-low window are supported. The host must present the next i_tx_data before the falling SCLK edge that follows o_tx_done.
- **Simultaneous events**: CS rising in the same cycle as an SCLK edge is processed as CS rising only; that SCLK edge is ignored.
- **Fixed behaviours**
  - SCLK edges while CS is high are ignored.
  - No parity, no CRC, fixed mode 0.

## Timing
- **Reset values**: o_rx_data 0, o_rx_done 0, o_tx_done 0, o_busy 0, o_abort 0, o_spi_miso 0, o_spi_miso_en 0. Shift registers, bit_cnt and reload are 0; the state is IDLE.
- **Latency**: any pin transition takes effect at the 3rd i_clk rising edge after it is captured (2 sync stages + 1 registered action).
- **Rate limit**: SCLK high and low phases must each be ≥ 4 i_clk periods.
- **Setup margin**: MISO changes ≤ 3 i_clk after SCLK falls, which leaves ≥ 1 i_clk of margin before the master samples on the next SCLK rise.
- **Pulse width**: o_rx_done, o_tx_done and o_abort are exactly 1 i_clk wide. Two completions are ≥ 8 SCLK edges apart.
- **Reset mid-frame**: all state clears immediately. After reset release, the block waits in IDLE for a fresh CS falling edge; a CS already low at release is not treated as a frame start.

## Test plan
- **Single byte**: i_tx_data=8'hA5; master sends 8'h3C at i_clk/16.
  - o_rx_data=8'h3C with one o_rx_done pulse.
  - The master captures 8'hA5 on MISO.
  - o_tx_done pulses in the same cycle as o_rx_done.
- **Burst**: CS held low for 3 bytes, 8'h01/8'h02/8'h03 out. i_tx_data is updated to 8'h10/8'h20/8'h30 on each o_tx_done.
  - Three o_rx_done pulses with matching data.
  - The master receives 8'h10, 8'h20, 8'h30.
- **Abort**: CS raised after 5 SCLK rises.
  - o_abort pulses once; no o_rx_done.
  - o_rx_data keeps its prior value.
  - A following full byte 8'hFF is received correctly.
- **Idle noise**: SCLK toggles 20 times with CS high.
  - No pulses; o_busy=0; o_spi_miso_en=0.
- **Reset mid-frame**: i_rst_n asserted after 4 bits.
  - All outputs return to reset values within the same cycle.
  - The next CS frame sending 8'h5A yields o_rx_data=8'h5A.
- **Max rate**: SCLK = i_clk/8, random bytes for 256 frames.
  - Zero RX and TX mismatches.
